// File: rtl/ace_snoop_collector.sv
// ACE snoop fan-out / CR response collector.
// One AC request broadcast to all masters; CR responses merged into one.
package snoop_pkg;
  typedef logic [3:0] acsnoop_t;
  typedef logic [2:0] acprot_t;
  typedef struct packed {
    logic was_unique;
    logic is_shared;
    logic pass_dirty;
    logic error;
    logic data_transfer;
  } crresp_t;
  localparam acsnoop_t SNP_READ_SHARED  = 4'b0001;
  localparam acsnoop_t SNP_DVM_COMPLETE = 4'b1110;
  localparam acsnoop_t SNP_DVM_MESSAGE  = 4'b1111;
endpackage

module ace_snoop_collector
  import snoop_pkg::*;
#(
  parameter int unsigned NoPorts   = 2,
  parameter int unsigned AddrWidth = 64,
  parameter int unsigned IdxW      = NoPorts > 1 ? $clog2(NoPorts) : 1
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   slv_ac_valid_i,
  output logic                   slv_ac_ready_o,
  input  logic [AddrWidth-1:0]   slv_ac_addr_i,
  input  acsnoop_t               slv_ac_snoop_i,
  input  acprot_t                slv_ac_prot_i,
  output logic [NoPorts-1:0]     mst_ac_valid_o,
  input  logic [NoPorts-1:0]     mst_ac_ready_i,
  output logic [AddrWidth-1:0]   mst_ac_addr_o,
  output acsnoop_t               mst_ac_snoop_o,
  output acprot_t                mst_ac_prot_o,
  input  logic [NoPorts-1:0]     mst_cr_valid_i,
  output logic [NoPorts-1:0]     mst_cr_ready_o,
  input  logic [NoPorts*5-1:0]   mst_cr_resp_i,
  output logic                   slv_cr_valid_o,
  input  logic                   slv_cr_ready_i,
  output crresp_t                slv_cr_resp_o,
  output logic                   slv_cr_data_vld_o,
  output logic [IdxW-1:0]        slv_cr_data_sel_o
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]           state_q, state_d;
  logic [AddrWidth-1:0] addr_q, addr_d;
  acsnoop_t             snoop_q, snoop_d;
  acprot_t              prot_q, prot_d;
  logic [NoPorts-1:0]   ac_done_q, ac_done_d;
  logic [NoPorts-1:0]   cr_done_q, cr_done_d;
  crresp_t              acc_q, acc_d;
  logic                 sel_vld_q, sel_vld_d;
  logic [IdxW-1:0]      sel_q, sel_d;

  crresp_t              resp_a [NoPorts];
  logic [NoPorts-1:0]   ac_hs, cr_hs;
  logic                 in_wait, is_dvm;

  assign in_wait = state_q == S_WAIT;
  assign is_dvm  = snoop_q == SNP_DVM_MESSAGE ||
                   snoop_q == SNP_DVM_COMPLETE;

  assign slv_ac_ready_o = state_q == S_IDLE;
  assign mst_ac_valid_o = in_wait ? ~ac_done_q : '0;
  assign mst_cr_ready_o = in_wait ? (ac_done_q & ~cr_done_q) : '0;
  assign ac_hs = mst_ac_valid_o & mst_ac_ready_i;
  assign cr_hs = mst_cr_valid_i & mst_cr_ready_o;

  assign mst_ac_addr_o  = addr_q;
  assign mst_ac_snoop_o = snoop_q;
  assign mst_ac_prot_o  = prot_q;

  // DVM snoops never move data, whatever the masters claim
  always_comb begin
    slv_cr_resp_o = acc_q;
    if (is_dvm) begin
      slv_cr_resp_o.data_transfer = 1'b0;
      slv_cr_resp_o.pass_dirty    = 1'b0;
    end
  end
  assign slv_cr_valid_o    = state_q == S_RESP;
  assign slv_cr_data_vld_o = sel_vld_q & ~is_dvm;
  assign slv_cr_data_sel_o = sel_q;

  always_comb begin
    for (int i = 0; i < NoPorts; i++) begin
      resp_a[i] = crresp_t'(mst_cr_resp_i[5*i +: 5]);
    end
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    snoop_d   = snoop_q;
    prot_d    = prot_q;
    ac_done_d = ac_done_q;
    cr_done_d = cr_done_q;
    acc_d     = acc_q;
    sel_vld_d = sel_vld_q;
    sel_d     = sel_q;
    unique case (state_q)
      S_IDLE: begin
        if (slv_ac_valid_i) begin
          addr_d    = slv_ac_addr_i;
          snoop_d   = slv_ac_snoop_i;
          prot_d    = slv_ac_prot_i;
          ac_done_d = '0;
          cr_done_d = '0;
          acc_d     = '0;
          sel_vld_d = 1'b0;
          sel_d     = '0;
          state_d   = S_WAIT;
        end
      end
      S_WAIT: begin
        ac_done_d = ac_done_q | ac_hs;
        cr_done_d = cr_done_q | cr_hs;
        // ascending scan: first recorded source sticks, lowest index wins ties
        for (int i = 0; i < NoPorts; i++) begin
          if (cr_hs[i]) begin
            acc_d = crresp_t'(acc_d | resp_a[i]);
            if (resp_a[i].data_transfer && !sel_vld_d) begin
              sel_vld_d = 1'b1;
              sel_d     = IdxW'(i);
            end
          end
        end
        if (&cr_done_d) state_d = S_RESP;
      end
      S_RESP: begin
        if (slv_cr_ready_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      snoop_q   <= '0;
      prot_q    <= '0;
      ac_done_q <= '0;
      cr_done_q <= '0;
      acc_q     <= '0;
      sel_vld_q <= 1'b0;
      sel_q     <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      snoop_q   <= snoop_d;
      prot_q    <= prot_d;
      ac_done_q <= ac_done_d;
      cr_done_q <= cr_done_d;
      acc_q     <= acc_d;
      sel_vld_q <= sel_vld_d;
      sel_q     <= sel_d;
    end
  end

endmodule

// File: tb/tb_ace_snoop_collector.sv
// Directed bench for ace_snoop_collector, NoPorts=2.
// CR encoding: {wasUnique,isShared,passDirty,error,dataTransfer}.
module tb_ace_snoop_collector;
  import snoop_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ac_valid = 1'b0;
  logic        ac_ready;
  logic [63:0] ac_addr = '0;
  acsnoop_t    ac_snoop = '0;
  acprot_t     ac_prot = '0;
  logic [1:0]  m_ac_valid;
  logic [1:0]  m_ac_ready = '0;
  logic [63:0] m_ac_addr;
  acsnoop_t    m_ac_snoop;
  acprot_t     m_ac_prot;
  logic [1:0]  m_cr_valid = '0;
  logic [1:0]  m_cr_ready;
  logic [9:0]  m_cr_resp = '0;
  logic        cr_valid;
  logic        cr_ready = 1'b0;
  crresp_t     cr_resp;
  logic        data_vld;
  logic [0:0]  data_sel;

  int checks = 0;
  int errors = 0;

  ace_snoop_collector #(.NoPorts(2), .AddrWidth(64)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .slv_ac_valid_i(ac_valid), .slv_ac_ready_o(ac_ready),
    .slv_ac_addr_i(ac_addr), .slv_ac_snoop_i(ac_snoop),
    .slv_ac_prot_i(ac_prot),
    .mst_ac_valid_o(m_ac_valid), .mst_ac_ready_i(m_ac_ready),
    .mst_ac_addr_o(m_ac_addr), .mst_ac_snoop_o(m_ac_snoop),
    .mst_ac_prot_o(m_ac_prot),
    .mst_cr_valid_i(m_cr_valid), .mst_cr_ready_o(m_cr_ready),
    .mst_cr_resp_i(m_cr_resp),
    .slv_cr_valid_o(cr_valid), .slv_cr_ready_i(cr_ready),
    .slv_cr_resp_o(cr_resp), .slv_cr_data_vld_o(data_vld),
    .slv_cr_data_sel_o(data_sel)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    ac_valid = 1'b0; m_ac_ready = '0; m_cr_valid = '0;
    m_cr_resp = '0; cr_ready = 1'b0;
  endtask

  // drives the request for cycle 0, returns in cycle 1
  task automatic accept(input logic [63:0] a, input acsnoop_t s);
    ac_addr = a; ac_snoop = s; ac_prot = 3'b010; ac_valid = 1'b1;
    chk("acc_rdy", 64'(ac_ready), 64'd1);
    tick();
    ac_valid = 1'b0;
  endtask

  initial begin
    #2;
    chk("rst_ac_ready", 64'(ac_ready), 64'd1);
    chk("rst_mac_valid", 64'(m_ac_valid), 64'd0);
    chk("rst_mcr_ready", 64'(m_cr_ready), 64'd0);
    chk("rst_cr_valid", 64'(cr_valid), 64'd0);
    chk("rst_cr_resp", 64'(cr_resp), 64'd0);
    chk("rst_addr", m_ac_addr, 64'd0);
    #10 rst_n = 1'b1;
    tick();

    // basic ReadShared: m0 isShared, m1 clean
    m_ac_ready = 2'b11; m_cr_valid = 2'b11;
    m_cr_resp = {5'b00000, 5'b01000};
    accept(64'h1000, SNP_READ_SHARED);
    chk("b1_mac_valid", 64'(m_ac_valid), 64'd3);
    chk("b1_ac_ready", 64'(ac_ready), 64'd0);
    chk("b1_cr_held", 64'(m_cr_ready), 64'd0);
    chk("b1_addr", m_ac_addr, 64'h1000);
    chk("b1_snoop", 64'(m_ac_snoop), 64'd1);
    tick();
    chk("b2_mcr_ready", 64'(m_cr_ready), 64'd3);
    chk("b2_mac_valid", 64'(m_ac_valid), 64'd0);
    chk("b2_cr_valid", 64'(cr_valid), 64'd0);
    tick();
    chk("b3_cr_valid", 64'(cr_valid), 64'd1);
    chk("b3_resp", 64'(cr_resp), 64'b01000);
    chk("b3_data_vld", 64'(data_vld), 64'd0);
    cr_ready = 1'b1;
    tick();
    chk("b4_idle", 64'(ac_ready), 64'd1);
    chk("b4_cr_valid", 64'(cr_valid), 64'd0);
    quiet();

    // staggered: m1 AC late, m1 data first, m0 data two cycles later
    m_ac_ready = 2'b01;
    accept(64'h2040, 4'b0111);
    tick(); tick();
    chk("s2_mac_valid", 64'(m_ac_valid), 64'd2);
    chk("s2_mcr_ready", 64'(m_cr_ready), 64'd1);
    tick();
    m_ac_ready = 2'b11;
    tick();
    chk("s5_mcr_ready", 64'(m_cr_ready), 64'd3);
    m_cr_valid = 2'b10; m_cr_resp = {5'b00101, 5'b00000};
    tick();
    m_cr_valid = 2'b00;
    chk("s6_mcr_ready", 64'(m_cr_ready), 64'd1);
    tick();
    m_cr_valid = 2'b01; m_cr_resp = {5'b00000, 5'b00001};
    tick();
    m_cr_valid = 2'b00;
    chk("s8_cr_valid", 64'(cr_valid), 64'd1);
    chk("s8_resp", 64'(cr_resp), 64'b00101);
    chk("s8_data_vld", 64'(data_vld), 64'd1);
    chk("s8_data_sel", 64'(data_sel), 64'd1);
    cr_ready = 1'b1;
    tick();
    quiet();

    // simultaneous data responses, then 5 cycles of backpressure
    m_ac_ready = 2'b11; m_cr_valid = 2'b11;
    m_cr_resp = {5'b10001, 5'b00001};
    accept(64'h3000, 4'b0000);
    tick();
    chk("m2_mcr_ready", 64'(m_cr_ready), 64'd3);
    tick();
    m_cr_valid = 2'b00;
    for (int k = 0; k < 5; k++) begin
      chk("bp_cr_valid", 64'(cr_valid), 64'd1);
      chk("bp_resp", 64'(cr_resp), 64'b10001);
      chk("bp_data_sel", 64'(data_sel), 64'd0);
      chk("bp_data_vld", 64'(data_vld), 64'd1);
      chk("bp_ac_ready", 64'(ac_ready), 64'd0);
      tick();
    end
    cr_ready = 1'b1;
    ac_valid = 1'b1;
    chk("m_exit_no_acc", 64'(ac_ready), 64'd0);
    tick();
    ac_valid = 1'b0;
    chk("m_back_idle", 64'(ac_ready), 64'd1);
    chk("m_addr_kept", m_ac_addr, 64'h3000);
    quiet();

    // early CR from m0 before its AC handshake
    m_cr_valid = 2'b01;
    accept(64'h4000, SNP_READ_SHARED);
    chk("e1_mcr_ready", 64'(m_cr_ready), 64'd0);
    tick();
    chk("e2_mcr_ready", 64'(m_cr_ready), 64'd0);
    m_ac_ready = 2'b11;
    tick();
    chk("e3_mcr_ready", 64'(m_cr_ready), 64'd3);
    m_cr_valid = 2'b11;
    tick();
    chk("e4_cr_valid", 64'(cr_valid), 64'd1);
    chk("e4_resp", 64'(cr_resp), 64'd0);
    cr_ready = 1'b1;
    tick();
    quiet();

    // DVM message: data and dirty suppressed, error kept
    m_ac_ready = 2'b11; m_cr_valid = 2'b11;
    m_cr_resp = {5'b00011, 5'b00101};
    accept(64'h5000, SNP_DVM_MESSAGE);
    tick(); tick();
    chk("d_cr_valid", 64'(cr_valid), 64'd1);
    chk("d_resp", 64'(cr_resp), 64'b00010);
    chk("d_data_vld", 64'(data_vld), 64'd0);
    cr_ready = 1'b1;
    tick();
    quiet();

    // asynchronous reset while in WAIT
    accept(64'h6000, SNP_READ_SHARED);
    chk("r_pre_valid", 64'(m_ac_valid), 64'd3);
    #2 rst_n = 1'b0;
    #1;
    chk("r_mac_valid", 64'(m_ac_valid), 64'd0);
    chk("r_cr_valid", 64'(cr_valid), 64'd0);
    chk("r_ac_ready", 64'(ac_ready), 64'd1);
    chk("r_addr", m_ac_addr, 64'd0);
    #3 rst_n = 1'b1;
    tick();
    chk("r_after_ready", 64'(ac_ready), 64'd1);
    chk("r_after_valid", 64'(m_ac_valid), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
